// File: rtl/disp_scan_ctrl_if.sv
// Memory-check read port between the display scanner and the memory.
// The scanner is the master: it issues chk_req/chk_addr and waits for chk_ack.
interface disp_scan_ctrl_if;
    logic       chk_req;
    logic [7:0] chk_addr;
    logic [7:0] chk_data;
    logic       chk_ack;

    modport master (output chk_req, chk_addr, input  chk_data, chk_ack);
    modport slave  (input  chk_req, chk_addr, output chk_data, chk_ack);
endinterface

// File: rtl/disp_scan_ctrl.sv
// 7-segment display path controller: run view (MAR/R/AC/Z) or memory-check view with
// req/ack check reads, auto-scroll or step. Optional read timeout: define CHK_TIMEOUT_EN.
module disp_scan_ctrl #(
    parameter int         DWELL     = 50,
    parameter logic [1:0] CHK_STATE = 2'b10
) (
    input  logic                light_clk,
    input  logic                clr,
    input  logic [1:0]          State,
    input  logic                auto_en,
    input  logic                step_btn,
    input  logic [7:0]          MAR,
    input  logic [7:0]          R,
    input  logic [7:0]          AC,
    input  logic                Z,
    disp_scan_ctrl_if.master    bus,
    output logic [31:0]         digits,
    output logic [7:0]          blank,
    output logic                page,
    output logic                chk_err
);
    localparam int             DW       = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]  DWELL_LD = DW'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SHOW} scan_st_t;

    scan_st_t       st;
    logic           chk_req_q;
    logic [7:0]     chk_addr_q;
    logic [7:0]     data_q;
    logic [DW-1:0]  dwell;
    logic           step_d;
    logic           step_pulse;
    logic           in_chk;
    logic           adv;
    logic           err_blank;
    logic [7:0][3:0] dig_nxt;
    logic [7:0]     blank_nxt;

    assign bus.chk_req  = chk_req_q;
    assign bus.chk_addr = chk_addr_q;

    assign in_chk     = (State == CHK_STATE);
    assign step_pulse = step_btn & ~step_d;
    // Step and dwell expiry coincide into a single advance.
    assign adv        = step_pulse | (auto_en & (dwell == '0));

`ifdef CHK_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    assign err_blank = chk_err;
`else
    assign err_blank = 1'b0;
    assign chk_err   = 1'b0;
`endif

    always_comb begin
        dig_nxt   = '0;
        blank_nxt = 8'hF0;
        if (!page) begin
            dig_nxt[0] = MAR[3:0];
            dig_nxt[1] = MAR[7:4];
            dig_nxt[2] = R[3:0];
            dig_nxt[3] = R[7:4];
            dig_nxt[4] = AC[3:0];
            dig_nxt[5] = AC[7:4];
            dig_nxt[6] = {3'b000, Z};
            blank_nxt  = 8'h80;
        end else begin
            dig_nxt[0] = chk_addr_q[3:0];
            dig_nxt[1] = chk_addr_q[7:4];
            dig_nxt[2] = data_q[3:0];
            dig_nxt[3] = data_q[7:4];
            // Data digits are stale while a read is pending or after a failed read.
            blank_nxt  = ((st == S_REQ) || err_blank) ? 8'hFC : 8'hF0;
        end
    end

    always_ff @(posedge light_clk) begin
        if (clr) begin
            st         <= S_IDLE;
            chk_req_q  <= 1'b0;
            chk_addr_q <= 8'h00;
            data_q     <= 8'h00;
            dwell      <= '0;
            step_d     <= 1'b0;
            digits     <= 32'h0;
            blank      <= 8'hFF;
            page       <= 1'b0;
`ifdef CHK_TIMEOUT_EN
            chk_err    <= 1'b0;
            tmo_cnt    <= 4'd0;
`endif
        end else begin
            step_d <= step_btn;
            page   <= in_chk;
            digits <= dig_nxt;
            blank  <= blank_nxt;
            case (st)
                S_IDLE: begin
                    chk_req_q <= 1'b0;
                    if (in_chk) begin
                        st        <= S_REQ;
                        chk_req_q <= 1'b1;
`ifdef CHK_TIMEOUT_EN
                        tmo_cnt   <= 4'd0;
`endif
                    end
                end
                S_REQ: begin
                    if (!in_chk) begin
                        st        <= S_IDLE;
                        chk_req_q <= 1'b0;
                    end else if (bus.chk_ack) begin
                        data_q    <= bus.chk_data;
                        dwell     <= DWELL_LD;
                        st        <= S_SHOW;
                        chk_req_q <= 1'b0;
`ifdef CHK_TIMEOUT_EN
                        chk_err   <= 1'b0;
                    end else if (tmo_cnt == 4'd14) begin
                        // 15th cycle in S_REQ without an ack: give up on this address.
                        data_q    <= 8'h00;
                        chk_err   <= 1'b1;
                        dwell     <= DWELL_LD;
                        st        <= S_SHOW;
                        chk_req_q <= 1'b0;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 4'd1;
`endif
                    end
                end
                S_SHOW: begin
                    if (!in_chk) begin
                        st <= S_IDLE;
                    end else if (adv) begin
                        chk_addr_q <= chk_addr_q + 8'd1;
                        st         <= S_REQ;
                        chk_req_q  <= 1'b1;
`ifdef CHK_TIMEOUT_EN
                        tmo_cnt    <= 4'd0;
`endif
                    end else if (dwell != '0) begin
                        dwell <= dwell - DW'(1);
                    end
                end
                default: begin
                    st        <= S_IDLE;
                    chk_req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (DWELL=4): run-view vector table plus check-view sequences.
module tb_disp_scan_ctrl;
    logic       light_clk = 1'b0;
    logic       clr;
    logic [1:0] State;
    logic       auto_en;
    logic       step_btn;
    logic [7:0] MAR, R, AC;
    logic       Z;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        page;
    logic        chk_err;
    logic        auto_ack;
    logic        man_ack;
    logic [7:0]  man_data;
    int          total = 0;
    int          bad   = 0;

    disp_scan_ctrl_if bus ();
    assign bus.chk_ack  = auto_ack ? bus.chk_req : man_ack;
    assign bus.chk_data = man_data;

    disp_scan_ctrl #(.DWELL(4), .CHK_STATE(2'b10)) dut (
        .light_clk (light_clk),
        .clr       (clr),
        .State     (State),
        .auto_en   (auto_en),
        .step_btn  (step_btn),
        .MAR       (MAR),
        .R         (R),
        .AC        (AC),
        .Z         (Z),
        .bus       (bus),
        .digits    (digits),
        .blank     (blank),
        .page      (page),
        .chk_err   (chk_err)
    );

    always #5 light_clk = ~light_clk;

    task automatic tick();
        @(posedge light_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  mar, r, ac;
        logic        z;
        logic [31:0] exp_dig;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int n;
        vecs[0] = '{mar: 8'h3C, r: 8'hA5, ac: 8'h0F, z: 1'b1, exp_dig: 32'h010FA53C};
        vecs[1] = '{mar: 8'h00, r: 8'h00, ac: 8'h00, z: 1'b0, exp_dig: 32'h00000000};
        vecs[2] = '{mar: 8'hFF, r: 8'hFF, ac: 8'hFF, z: 1'b1, exp_dig: 32'h01FFFFFF};
        vecs[3] = '{mar: 8'h12, r: 8'h34, ac: 8'h56, z: 1'b0, exp_dig: 32'h00563412};
        vecs[4] = '{mar: 8'hA0, r: 8'h0B, ac: 8'hC7, z: 1'b1, exp_dig: 32'h01C70BA0};

        // Reset with random inputs
        clr = 1'b1; State = 2'(CHK_ST()); auto_en = 1'($urandom);
        step_btn = 1'($urandom); MAR = 8'($urandom); R = 8'($urandom);
        AC = 8'($urandom); Z = 1'($urandom); auto_ack = 1'b0;
        man_ack = 1'($urandom); man_data = 8'($urandom);
        tick(); tick();
        chk("rst_req",    {31'b0, bus.chk_req}, 32'd0);
        chk("rst_addr",   {24'b0, bus.chk_addr}, 32'h00);
        chk("rst_blank",  {24'b0, blank}, 32'hFF);
        chk("rst_digits", digits, 32'h0);
        chk("rst_page",   {31'b0, page}, 32'd0);
        chk("rst_err",    {31'b0, chk_err}, 32'd0);

        // Run-view vector table
        clr = 1'b0; State = 2'b00; auto_en = 1'b0; step_btn = 1'b0; man_ack = 1'b0;
        foreach (vecs[i]) begin
            MAR = vecs[i].mar; R = vecs[i].r; AC = vecs[i].ac; Z = vecs[i].z;
            tick(); tick();
            chk($sformatf("run_dig[%0d]", i), digits, vecs[i].exp_dig);
            chk($sformatf("run_blank[%0d]", i), {24'b0, blank}, 32'h80);
            chk($sformatf("run_page[%0d]", i), {31'b0, page}, 32'd0);
        end

        // Check view, manual step, ack two cycles after req
        State = 2'b10; man_data = 8'h5A;
        tick();
        chk("s2_req1",  {31'b0, bus.chk_req}, 32'd1);
        chk("s2_page",  {31'b0, page}, 32'd1);
        tick();
        chk("s2_req2",  {31'b0, bus.chk_req}, 32'd1);
        chk("s2_blank_req", {24'b0, blank}, 32'hFC);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("s2_req_drop", {31'b0, bus.chk_req}, 32'd0);
        tick();
        chk("s2_dig", digits, 32'h00005A00);
        chk("s2_blank_show", {24'b0, blank}, 32'hF0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.chk_req) seen = 1'b1;
        end
        chk("s2_no_req_wo_step", {31'b0, seen}, 32'd0);
        step_btn = 1'b1;
        tick();
        chk("s2_step_addr", {24'b0, bus.chk_addr}, 32'h01);
        chk("s2_step_req",  {31'b0, bus.chk_req}, 32'd1);
        man_data = 8'hC3; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.chk_req) seen = 1'b1;
        end
        chk("s2_held_no_repeat", {31'b0, seen}, 32'd0);
        chk("s2_held_addr", {24'b0, bus.chk_addr}, 32'h01);
        step_btn = 1'b0;
        man_data = 8'hEE; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("s2_stray_ack", digits, 32'h0000C301);

        // Auto advance, immediate ack, DWELL=4
        clr = 1'b1;
        tick();
        clr = 1'b0; auto_en = 1'b1; auto_ack = 1'b1; man_data = 8'h11;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("s3_req[%0d]", k), {31'b0, bus.chk_req},
                (k == 1 || k == 6 || k == 11) ? 32'd1 : 32'd0);
            chk($sformatf("s3_addr[%0d]", k), {24'b0, bus.chk_addr}, 32'((k - 1) / 5));
        end

        // Wrap at FF with step and dwell expiry together
        n = 0;
        while (!(bus.chk_addr == 8'hFF && bus.chk_req) && n < 2000) begin
            tick();
            n++;
        end
        chk("s4_reach_ff", {31'b0, (n < 2000)}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        chk("s4_wrap_addr", {24'b0, bus.chk_addr}, 32'h00);
        chk("s4_wrap_req",  {31'b0, bus.chk_req}, 32'd1);
        tick();
        auto_en = 1'b0; auto_ack = 1'b0;
        chk("s4_single_inc", {24'b0, bus.chk_addr}, 32'h00);
        chk("s4_req_done",   {31'b0, bus.chk_req}, 32'd0);

        // Leave check state while a read is pending
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        chk("s5_req", {31'b0, bus.chk_req}, 32'd1);
        State = 2'b01;
        tick();
        chk("s5_leave_req",  {31'b0, bus.chk_req}, 32'd0);
        chk("s5_leave_page", {31'b0, page}, 32'd0);
        tick();
        chk("s5_run_blank", {24'b0, blank}, 32'h80);
        State = 2'b10;
        tick();
        chk("s5_rereq",      {31'b0, bus.chk_req}, 32'd1);
        chk("s5_rereq_addr", {24'b0, bus.chk_addr}, 32'h01);

`ifdef CHK_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        chk("s6_pre_tmo_req", {31'b0, bus.chk_req}, 32'd1);
        chk("s6_pre_tmo_err", {31'b0, chk_err}, 32'd0);
        tick();
        chk("s6_tmo_err", {31'b0, chk_err}, 32'd1);
        chk("s6_tmo_req", {31'b0, bus.chk_req}, 32'd0);
        tick();
        chk("s6_tmo_blank", {24'b0, blank}, 32'hFC);
        chk("s6_tmo_dig",   digits, 32'h00000001);
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        man_data = 8'h77; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("s6_err_clr", {31'b0, chk_err}, 32'd0);
        tick();
        chk("s6_dig",   digits, 32'h00007702);
        chk("s6_blank", {24'b0, blank}, 32'hF0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("s6_wait_req", {31'b0, bus.chk_req}, 32'd1);
        chk("s6_no_err",   {31'b0, chk_err}, 32'd0);
        man_data = 8'h3E; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("s6_dig",   digits, 32'h00003E01);
        chk("s6_blank", {24'b0, blank}, 32'hF0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [1:0] CHK_ST();
        return 2'($urandom);
    endfunction
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Controller that drives the 7-segment display path of the 8-bit CPU board.
- Chooses what the HEX digits show: the run view (MAR/R/AC/Z) or the memory-check view.
- In check state it sequences memory check reads through a req/ack handshake, auto-scrolling or stepping through addresses.
- Outputs registered nibbles plus a blank mask; a downstream hex decoder turns these into segments.

Parameters:
- DWELL, 50, light_clk cycles a check address is shown before auto-advance (>=2).
- CHK_STATE, 2'b10, CPU State encoding that means "check".

Ports:
- light_clk  in  1  display clock from clock divider.
- clr  in  1  synchronous active-high reset, sampled on rising light_clk.
- State  in  2  CPU controller state.
- auto_en  in  1  1 = auto-advance check address every DWELL cycles.
- step_btn  in  1  synchronised step button level; rising edge = advance.
- MAR  in  8  current address.
- R  in  8  R register value.
- AC  in  8  AC register value.
- Z  in  1  zero flag.
- chk_data  in  8  memory check read data, valid with chk_ack.
- chk_ack  in  1  memory check read complete (1-cycle pulse).
- chk_req  out  1  memory check read request.
- chk_addr  out  8  memory check read address.
- digits  out  32  8 nibbles; digit k = digits[4k+3:4k].
- blank  out  8  bit k = 1 blanks digit k.
- page  out  1  0 = run view, 1 = check view.
- chk_err  out  1  last check read timed out (optional feature only, else 0).

Behaviour:
- Reset (clr=1 at edge):
  - Scanner FSM goes to S_IDLE.
  - chk_req=0, chk_addr=8'h00, data_q=8'h00.
  - Dwell counter=0, step_d=0.
  - digits=32'h0, blank=8'hFF, page=0, chk_err=0.
  - clr overrides every other input in that cycle.
- Step edge: step_d registers step_btn; step_pulse = step_btn & ~step_d. This gives one pulse per press; a held button does not repeat.
- page is registered: page <= (State==CHK_STATE).
- Scanner FSM:
  - S_IDLE: chk_req=0. If State==CHK_STATE, go to S_REQ.
  - S_REQ: chk_req=1, chk_addr stable. On chk_ack: data_q<=chk_data, dwell<=DWELL-1, go to S_SHOW. Step pulses are ignored here.
  - S_SHOW: chk_req=0. dwell decrements toward 0 and saturates at 0.
    - Advance condition: step_pulse, or (auto_en and dwell==0).
    - On advance: chk_addr<=chk_addr+1 (8'hFF wraps to 8'h00), go to S_REQ.
    - A step pulse and dwell expiry in the same cycle give exactly one increment.
- Leaving check state: if State!=CHK_STATE in any non-idle state, go to S_IDLE next edge.
  - chk_req is 0 from that edge onward.
  - chk_addr and data_q are retained; re-entering check re-reads the same address.
- chk_ack outside S_REQ is ignored and does not update data_q.
- Display mux, registered (one cycle latency from inputs/data_q to digits):
  - page=0: d0=MAR[3:0], d1=MAR[7:4], d2=R[3:0], d3=R[7:4], d4=AC[3:0], d5=AC[7:4], d6={3'b0,Z}, d7=0. blank=8'b1000_0000.
  - page=1: d0=chk_addr[3:0], d1=chk_addr[7:4], d2=data_q[3:0], d3=data_q[7:4], others 0. blank=8'b1111_0000. While the FSM is in S_REQ, d2/d3 are also blanked (blank=8'b1111_1100).

Optional Feature:
- Macro: CHK_TIMEOUT_EN.
- Defined:
  - A 4-bit counter runs in S_REQ.
  - If no chk_ack within 15 cycles of entering S_REQ: data_q<=8'h00, chk_err<=1, go to S_SHOW.
  - A successful ack clears chk_err.
  - While chk_err=1 on page 1, d2/d3 stay blanked.
- Not defined: S_REQ waits indefinitely for chk_ack, and chk_err is tied to 0.

Test Plan:
- clr=1 for 2 cycles with random inputs -> chk_req=0, chk_addr=00, blank=FF, digits=0; after release with State=00, MAR=3C, R=A5, AC=0F, Z=1 -> 2 cycles later digits=0x010FA53C, blank=80.
- State=10, auto_en=0, ack 2 cycles after each req with chk_data=5A -> chk_req high until ack; data_q=5A; no further req until a step edge; step edge -> chk_addr=01, new req.
- auto_en=1, DWELL=4, immediate ack -> chk_addr advances 00->01->02; S_SHOW lasts exactly 4 cycles each.
- chk_addr=FF with step edge and dwell expiry in the same cycle -> chk_addr=00, single req.
- State goes 10->01 while in S_REQ -> chk_req=0 next edge, page=0; return to 10 -> req re-issued at the same chk_addr.
- With CHK_TIMEOUT_EN, never ack -> 15 cycles later chk_err=1, d2/d3 blanked; the next read acked with 77 -> chk_err=0, d3:d2=7,7.
